// File: rtl/stage2_n_select_pipe_pkg.sv
// Shared constants, buffer-state encoding and helpers for the stage-2 N-type selector pipe.
// Control codes and message width mirror the para_def.v values used by the stage-2/3 blocks.
package stage2_n_select_pipe_pkg;

    localparam int N_TYPE_CONTROL_WIDTH = 3;
    localparam int MAX_MESSAGE_BITS     = 8;
    localparam int NUM_SRC              = 5;
    localparam int ERR_W                = 16;

    localparam logic [N_TYPE_CONTROL_WIDTH-1:0] N_TYPE_L = 3'd0;
    localparam logic [N_TYPE_CONTROL_WIDTH-1:0] N_TYPE_M = 3'd1;
    localparam logic [N_TYPE_CONTROL_WIDTH-1:0] N_TYPE_N = 3'd2;
    localparam logic [N_TYPE_CONTROL_WIDTH-1:0] N_TYPE_R = 3'd3;
    localparam logic [N_TYPE_CONTROL_WIDTH-1:0] N_TYPE_S = 3'd4;

    localparam logic [MAX_MESSAGE_BITS-1:0] DEFAUT_MESSAGE = 8'd0;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        logic [ERR_W-1:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stage2_n_select_pipe_n_select_ch.sv
// One channel of the N-type selector: five candidates plus a control code give the
// chosen message and a flag for an unrecognised code.
module n_select_ch
    import stage2_n_select_pipe_pkg::*;
#(
    parameter int               MSG_W       = MAX_MESSAGE_BITS,
    parameter int               CTRL_W      = N_TYPE_CONTROL_WIDTH,
    parameter logic [MSG_W-1:0] DEFAULT_MSG = MSG_W'(DEFAUT_MESSAGE)
) (
    input  logic [NUM_SRC*MSG_W-1:0] cand,
    input  logic [CTRL_W-1:0]        ctrl,
    output logic [MSG_W-1:0]         msg,
    output logic                     bad
);

    // Decode the control code into a candidate pick or the default message.
    always_comb begin
        msg = DEFAULT_MSG;
        bad = 1'b0;
        case (ctrl)
            CTRL_W'(N_TYPE_L): msg = cand[0*MSG_W +: MSG_W];
            CTRL_W'(N_TYPE_M): msg = cand[1*MSG_W +: MSG_W];
            CTRL_W'(N_TYPE_N): msg = cand[2*MSG_W +: MSG_W];
            CTRL_W'(N_TYPE_R): msg = cand[3*MSG_W +: MSG_W];
            CTRL_W'(N_TYPE_S): msg = cand[4*MSG_W +: MSG_W];
            default: begin
                msg = DEFAULT_MSG;
                bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/stage2_n_select_pipe.sv
// Stage-2 N-type message selector: per-channel selection feeding a two-entry
// valid/ready skid buffer, plus a saturating count of beats carrying illegal codes.
module stage2_n_select_pipe
    import stage2_n_select_pipe_pkg::*;
#(
    parameter int               MSG_W       = MAX_MESSAGE_BITS,
    parameter int               NUM_CH      = 3,
    parameter int               CTRL_W      = N_TYPE_CONTROL_WIDTH,
    parameter logic [MSG_W-1:0] DEFAULT_MSG = MSG_W'(DEFAUT_MESSAGE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CH*NUM_SRC*MSG_W-1:0]  in_msg,
    input  logic [NUM_CH*CTRL_W-1:0]         in_ctrl,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [NUM_CH*MSG_W-1:0]          out_msg,
    output logic [NUM_CH-1:0]                out_bad,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic                             err_clr,
    output logic [ERR_W-1:0]                 err_cnt
);

    logic [NUM_CH*MSG_W-1:0] sel_msg_s;
    logic [NUM_CH-1:0]       sel_bad_s;
    logic                    accept_s;
    logic                    emit_s;

    buf_state_e              state_r;
    logic [NUM_CH*MSG_W-1:0] main_msg_r;
    logic [NUM_CH-1:0]       main_bad_r;
    logic [NUM_CH*MSG_W-1:0] skid_msg_r;
    logic [NUM_CH-1:0]       skid_bad_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [ERR_W-1:0]        err_cnt_r;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        n_select_ch #(
            .MSG_W       (MSG_W),
            .CTRL_W      (CTRL_W),
            .DEFAULT_MSG (DEFAULT_MSG)
        ) u_sel (
            .cand (in_msg[c*NUM_SRC*MSG_W +: NUM_SRC*MSG_W]),
            .ctrl (in_ctrl[c*CTRL_W +: CTRL_W]),
            .msg  (sel_msg_s[c*MSG_W +: MSG_W]),
            .bad  (sel_bad_s[c])
        );
    end

    // Handshakes use only registered flags, so in_ready never depends on out_ready.
    assign accept_s = in_valid && in_ready_r;
    assign emit_s   = out_valid_r && out_ready;

    // Skid-buffer occupancy FSM; in_ready/out_valid are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= BUF_EMPTY;
            main_msg_r  <= {(NUM_CH*MSG_W){1'b0}};
            main_bad_r  <= {NUM_CH{1'b0}};
            skid_msg_r  <= {(NUM_CH*MSG_W){1'b0}};
            skid_bad_r  <= {NUM_CH{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                BUF_EMPTY: begin
                    if (accept_s) begin
                        main_msg_r  <= sel_msg_s;
                        main_bad_r  <= sel_bad_s;
                        state_r     <= BUF_ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept_s && emit_s) begin
                        main_msg_r <= sel_msg_s;
                        main_bad_r <= sel_bad_s;
                    end else if (accept_s) begin
                        // Main is stalled, so the new beat parks in the skid slot.
                        skid_msg_r <= sel_msg_s;
                        skid_bad_r <= sel_bad_s;
                        state_r    <= BUF_TWO;
                        in_ready_r <= 1'b0;
                    end else if (emit_s) begin
                        state_r     <= BUF_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                BUF_TWO: begin
                    if (emit_s) begin
                        main_msg_r <= skid_msg_r;
                        main_bad_r <= skid_bad_r;
                        state_r    <= BUF_ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= BUF_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating illegal-beat counter; a clear wins over a same-cycle bad accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 16'd0;
        end else if (err_clr) begin
            err_cnt_r <= 16'd0;
        end else if (accept_s && (|sel_bad_s)) begin
            err_cnt_r <= sat_inc(err_cnt_r);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_msg   = main_msg_r;
    assign out_bad   = main_bad_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_stage2_n_select_pipe.sv
// Scoreboard bench for stage2_n_select_pipe: the driver queues the expected beat on
// every accept, and a monitor compares each presented output against the queue head.
module tb_stage2_n_select_pipe;

    localparam int MSG_W  = 8;
    localparam int NUM_CH = 3;
    localparam int CTRL_W = 3;
    localparam int IN_W   = NUM_CH * 5 * MSG_W;
    localparam int CT_W   = NUM_CH * CTRL_W;
    localparam int OUT_W  = NUM_CH * MSG_W;
    localparam int EXP_W  = OUT_W + NUM_CH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IN_W-1:0]   in_msg;
    logic [CT_W-1:0]   in_ctrl;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  out_msg;
    logic [NUM_CH-1:0] out_bad;
    logic              out_valid;
    logic              out_ready;
    logic              err_clr;
    logic [15:0]       err_cnt;

    logic [EXP_W-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stage2_n_select_pipe #(
        .MSG_W       (MSG_W),
        .NUM_CH      (NUM_CH),
        .CTRL_W      (CTRL_W),
        .DEFAULT_MSG (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_msg    (in_msg),
        .in_ctrl   (in_ctrl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_msg   (out_msg),
        .out_bad   (out_bad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Candidate (c, s) carries value c*5+s+1+base.
    function automatic logic [IN_W-1:0] mk_msg(input int base);
        logic [IN_W-1:0] m;
        m = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 5; s++) begin
                m[(c*5+s)*MSG_W +: MSG_W] = MSG_W'(c*5 + s + 1 + base);
            end
        end
        return m;
    endfunction

    function automatic logic [IN_W-1:0] flat_msg(input int value);
        logic [MSG_W-1:0] v;
        v = MSG_W'(value);
        return {(NUM_CH*5){v}};
    endfunction

    task automatic send(input logic [IN_W-1:0] m, input logic [CT_W-1:0] c,
                        input logic [EXP_W-1:0] e, input bit want_ready);
        int guard;
        guard    = 0;
        in_msg   = m;
        in_ctrl  = c;
        in_valid = 1'b1;
        @(negedge clk);
        if (want_ready) check("in_ready_in_one", 32'(in_ready), 32'd1);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the head beat whenever out_valid is up; pop only when it is taken.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_beat: got out_msg %h, expected no beat (t=%0t)", out_msg, $time);
            end else begin
                check(out_ready ? "out_msg" : "hold_msg", 32'(out_msg), 32'(exp_q[0][OUT_W-1:0]));
                check(out_ready ? "out_bad" : "hold_bad", 32'(out_bad), 32'(exp_q[0][EXP_W-1:OUT_W]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CT_W-1:0]  c;
        logic [EXP_W-1:0] e;
        int               code;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_msg    = '0;
        in_ctrl   = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_msg",   32'(out_msg),   32'd0);
        check("rst_out_bad",   32'(out_bad),   32'd0);
        check("rst_err_cnt",   32'(err_cnt),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Legal sweep: channel c uses code (i+c)%5 on beat i.
        for (int i = 0; i < 5; i++) begin
            c = '0;
            e = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                code = (i + ch) % 5;
                c[ch*CTRL_W +: CTRL_W] = CTRL_W'(code);
                e[ch*MSG_W +: MSG_W]   = MSG_W'(ch*5 + code + 1 + 16*i);
            end
            send(mk_msg(16*i), c, e, 1'b0);
        end
        drain();
        check("err_after_sweep", 32'(err_cnt), 32'd0);

        // Illegal codes: one bad channel, then two bad channels in one beat.
        send(mk_msg(0), {3'd4, 3'd7, 3'd0}, {3'b010, 8'd15, 8'd0, 8'd1}, 1'b0);
        drain();
        check("err_one_bad", 32'(err_cnt), 32'd1);
        send(mk_msg(0), {3'd6, 3'd1, 3'd5}, {3'b101, 8'd0, 8'd7, 8'd0}, 1'b0);
        drain();
        check("err_two_bad", 32'(err_cnt), 32'd2);

        // Back-pressure: 10 beats, out_ready low for three edges mid-stream.
        for (int i = 1; i <= 3; i++) send(flat_msg(i), '0, {3'b000, {3{8'(i)}}}, 1'b0);
        out_ready = 1'b0;
        send(flat_msg(4), '0, {3'b000, {3{8'd4}}}, 1'b0);
        @(negedge clk);
        check("bp_in_ready_full", 32'(in_ready),  32'd0);
        check("bp_out_valid",     32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 5; i <= 10; i++) send(flat_msg(i), '0, {3'b000, {3{8'(i)}}}, 1'b0);
            end
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_err_unchanged", 32'(err_cnt), 32'd2);

        // Accept and emit together in ONE: in_ready must stay high every cycle.
        send(flat_msg(8'h80), '0, {3'b000, {3{8'h80}}}, 1'b0);
        for (int i = 1; i <= 20; i++) send(flat_msg(8'h80 + i), '0, {3'b000, {3{8'(8'h80 + i)}}}, 1'b1);
        drain();

        // err_clr wins over a bad accept in the same cycle.
        err_clr = 1'b1;
        send(mk_msg(0), {3{3'd7}}, {3'b111, 24'h0}, 1'b0);
        err_clr = 1'b0;
        drain();
        check("err_clr_priority", 32'(err_cnt), 32'd0);

        // Saturation: 65534 bad beats reach FFFE, three more stick at FFFF.
        for (int i = 0; i < 65534; i++) send(mk_msg(0), {3{3'd7}}, {3'b111, 24'h0}, 1'b0);
        drain();
        check("err_fffe", 32'(err_cnt), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) send(mk_msg(0), {3{3'd7}}, {3'b111, 24'h0}, 1'b0);
        drain();
        check("err_saturate", 32'(err_cnt), 32'h0000FFFF);

        // Reset between edges while the buffer holds two beats.
        out_ready = 1'b0;
        send(flat_msg(8'h11), '0, {3'b000, {3{8'h11}}}, 1'b0);
        send(flat_msg(8'h22), '0, {3'b000, {3{8'h22}}}, 1'b0);
        @(negedge clk);
        check("two_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_err_cnt",   32'(err_cnt),   32'd0);
        check("arst_out_msg",   32'(out_msg),   32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(flat_msg(8'h5A), '0, {3'b000, {3{8'h5A}}}, 1'b0);
        drain();
        check("post_rst_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
